// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus: widths, source indices and station tags.
// Tag value zero is reserved to mean "no result" everywhere on the bus.
package cdb_arbiter_pkg;

    localparam int TAG_W  = 8;
    localparam int DATA_W = 32;
    localparam int BUS_W  = TAG_W + DATA_W;

    typedef enum logic [1:0] {
        SRC_ADD  = 2'd0,
        SRC_MULT = 2'd1,
        SRC_LD   = 2'd2
    } src_e;

    // Reservation-station tags; NULL_TAG marks an empty bus slot.
    localparam logic [TAG_W-1:0] NULL_TAG = 8'd0;
    localparam logic [TAG_W-1:0] A0       = 8'd1;
    localparam logic [TAG_W-1:0] A1       = 8'd2;
    localparam logic [TAG_W-1:0] A2       = 8'd3;
    localparam logic [TAG_W-1:0] M0       = 8'd4;
    localparam logic [TAG_W-1:0] M1       = 8'd5;
    localparam logic [TAG_W-1:0] LD0      = 8'd6;
    localparam logic [TAG_W-1:0] LD1      = 8'd7;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_res_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO; the caller guarantees no push when full and no pop when empty.
// Simultaneous push and pop advance both pointers and leave the count unchanged.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [BUS_W-1:0] i_data,
    output logic [BUS_W-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BUS_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered common data bus among the result producers.
// Each producer feeds its own FIFO; one head result is broadcast per cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NSRC  = 3,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC-1:0]       i_in_valid,
    input  logic [NSRC*BUS_W-1:0] i_in_res,
    output logic [NSRC-1:0]       o_in_ready,
    output logic [BUS_W-1:0]      o_cdb,
    output logic                  o_cdb_valid,
    output logic                  o_tag0_err
);

    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]  w_push;
    logic [NSRC-1:0]  w_pop;
    logic [NSRC-1:0]  w_full;
    logic [NSRC-1:0]  w_empty;
    logic [NSRC-1:0]  w_tag0;
    logic [BUS_W-1:0] w_head [NSRC];
    logic [IDX_W-1:0] w_grantIdx;
    logic             w_grantValid;

    logic [IDX_W-1:0] r_rrLast;
    logic [BUS_W-1:0] r_cdb;
    logic             r_cdbValid;
    logic             r_tag0Err;

    // Readiness depends on the FIFO count only, so a full FIFO refuses even while popping.
    generate
        for (genvar g = 0; g < NSRC; g++) begin : g_src
            cdb_res_t w_res;
            assign w_res     = i_in_res[g*BUS_W +: BUS_W];
            assign w_push[g] = i_in_valid[g] && !w_full[g] && (w_res.tag != NULL_TAG);
            assign w_tag0[g] = i_in_valid[g] && !w_full[g] && (w_res.tag == NULL_TAG);

            cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_push  (w_push[g]),
                .i_pop   (w_pop[g]),
                .i_data  (w_res),
                .o_data  (w_head[g]),
                .o_full  (w_full[g]),
                .o_empty (w_empty[g])
            );
        end
    endgenerate

    assign o_in_ready = ~w_full;

    // Scan from the source after the last grant, wrapping around, and take the first non-empty one.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] w_idx;
        w_grantValid = 1'b0;
        w_grantIdx   = r_rrLast;
        w_pop        = '0;
        idx          = 0;
        w_idx        = '0;
        for (int k = 1; k <= NSRC; k++) begin
            idx = int'(r_rrLast) + k;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            w_idx = IDX_W'(idx);
            if (!w_grantValid && !w_empty[w_idx]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = w_idx;
            end
        end
        if (w_grantValid) begin
            w_pop[w_grantIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb      <= '0;
            r_cdbValid <= 1'b0;
            r_rrLast   <= IDX_W'(NSRC - 1);
            r_tag0Err  <= 1'b0;
        end else begin
            if (w_grantValid) begin
                r_cdb      <= w_head[w_grantIdx];
                r_cdbValid <= 1'b1;
                r_rrLast   <= w_grantIdx;
            end else begin
                r_cdb      <= '0;
                r_cdbValid <= 1'b0;
            end
            r_tag0Err <= r_tag0Err | (|w_tag0);
        end
    end

    assign o_cdb       = r_cdb;
    assign o_cdb_valid = r_cdbValid;
    assign o_tag0_err  = r_tag0Err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: per-source queues and a round-robin pointer model the bus,
// and each scenario task compares the DUT against that model and against fixed values.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NSRC  = 3;
    localparam int DEPTH = 2;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NSRC-1:0]       vIn   = '0;
    logic [NSRC*BUS_W-1:0] rIn   = '0;
    logic [NSRC-1:0]       ready;
    logic [BUS_W-1:0]      cdb;
    logic                  cdbValid;
    logic                  tag0Err;

    logic [BUS_W-1:0] q [NSRC][$];
    int               rrLast;
    logic [BUS_W-1:0] expCdb;
    logic             expValid;
    logic             expErr;
    int               errors = 0;
    int               checks = 0;

    cdb_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (vIn),
        .i_in_res    (rIn),
        .o_in_ready  (ready),
        .o_cdb       (cdb),
        .o_cdb_valid (cdbValid),
        .o_tag0_err  (tag0Err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NSRC-1:0] modelReady();
        logic [NSRC-1:0] r;
        for (int i = 0; i < NSRC; i++) r[i] = (q[i].size() != DEPTH);
        return r;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NSRC; i++) q[i].delete();
        rrLast   = NSRC - 1;
        expCdb   = '0;
        expValid = 1'b0;
        expErr   = 1'b0;
    endtask

    task automatic setRes(input int s, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        rIn[s*BUS_W +: BUS_W] = {tag, data};
    endtask

    // Advance one clock: grant from the pre-edge queue contents, then accept pushes.
    task automatic cycle();
        logic [NSRC-1:0] rdy;
        rdy = modelReady();
        @(posedge clk);
        expValid = 1'b0;
        expCdb   = '0;
        for (int k = 1; k <= NSRC; k++) begin
            int s;
            s = (rrLast + k) % NSRC;
            if (!expValid && q[s].size() > 0) begin
                expCdb   = q[s].pop_front();
                expValid = 1'b1;
                rrLast   = s;
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (vIn[i] && rdy[i]) begin
                logic [BUS_W-1:0] e;
                e = rIn[i*BUS_W +: BUS_W];
                if (e[BUS_W-1 -: TAG_W] == NULL_TAG) expErr = 1'b1;
                else q[i].push_back(e);
            end
        end
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        vIn   = '0;
        rIn   = '0;
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        modelReset();
        checks += 4;
        if (cdb !== '0) begin errors++; $display("[TB] FAIL reset_cdb: got %h expected 0", cdb); end
        if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", cdbValid); end
        if (ready !== 3'b111) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 111", ready); end
        if (tag0Err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", tag0Err); end
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks += 3;
            if (cdb !== '0) begin errors++; $display("[TB] FAIL idle_cdb: got %h expected 0", cdb); end
            if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid: got %b expected 0", cdbValid); end
            if (ready !== 3'b111) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 111", ready); end
        end
    endtask

    task automatic test_single_push();
        rIn = '0;
        setRes(SRC_MULT, M0, 32'h0000_0015);
        vIn = 3'b010;
        cycle();
        vIn = '0;
        checks++;
        if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL single_early: got valid %b expected 0", cdbValid); end
        cycle();
        checks += 2;
        if (cdbValid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", cdbValid); end
        if (cdb !== 40'h04_0000_0015) begin errors++; $display("[TB] FAIL single_data: got %h expected 0400000015", cdb); end
        cycle();
        checks++;
        if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL single_hold: got valid %b expected 0", cdbValid); end
    endtask

    task automatic test_round_robin();
        logic [TAG_W-1:0] rrTag [NSRC];
        rrTag[0] = A0;
        rrTag[1] = M0;
        rrTag[2] = LD0;
        doReset();
        vIn = 3'b111;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NSRC; i++) setRes(i, rrTag[i], $urandom);
            checks++;
            if (ready !== modelReady()) begin errors++; $display("[TB] FAIL rr_ready: got %b expected %b", ready, modelReady()); end
            cycle();
            checks++;
            if (cdb !== expCdb) begin errors++; $display("[TB] FAIL rr_cdb: got %h expected %h", cdb, expCdb); end
            if (n >= 1) begin
                checks += 2;
                if (cdbValid !== 1'b1) begin errors++; $display("[TB] FAIL rr_valid: got %b expected 1", cdbValid); end
                if (cdb[BUS_W-1 -: TAG_W] !== rrTag[(n-1)%NSRC]) begin
                    errors++;
                    $display("[TB] FAIL rr_order: got tag %h expected %h", cdb[BUS_W-1 -: TAG_W], rrTag[(n-1)%NSRC]);
                end
            end
        end
        vIn = '0;
        for (int n = 0; n < 8; n++) cycle();
    endtask

    task automatic test_back_pressure();
        logic [BUS_W-1:0] got [$];
        logic [NSRC-1:0]  rdy;
        int               p2;
        doReset();
        p2 = 0;
        for (int n = 0; n < 24; n++) begin
            vIn[0] = 1'b1;
            vIn[1] = 1'b1;
            vIn[2] = (p2 < 3);
            setRes(SRC_ADD, TAG_W'($urandom_range(1, 3)), $urandom);
            setRes(SRC_MULT, TAG_W'($urandom_range(4, 5)), $urandom);
            setRes(SRC_LD, LD0, 32'hB000_0001 + p2);
            rdy = modelReady();
            checks++;
            if (ready !== rdy) begin errors++; $display("[TB] FAIL bp_ready: got %b expected %b", ready, rdy); end
            if (n == 2) begin
                checks++;
                if (ready[2] !== 1'b0) begin errors++; $display("[TB] FAIL bp_full: got ready2 %b expected 0", ready[2]); end
            end
            cycle();
            if (vIn[2] && rdy[2]) p2++;
            checks++;
            if (cdb !== expCdb || cdbValid !== expValid) begin
                errors++;
                $display("[TB] FAIL bp_cdb: got %h/%b expected %h/%b", cdb, cdbValid, expCdb, expValid);
            end
            if (cdbValid === 1'b1 && cdb[BUS_W-1 -: TAG_W] === LD0) got.push_back(cdb);
        end
        vIn = '0;
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d src2 results expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== {LD0, 32'hB000_0001 + i}) begin
                    errors++;
                    $display("[TB] FAIL bp_order: got %h expected %h", got[i], {LD0, 32'hB000_0001 + i});
                end
            end
        end
        for (int n = 0; n < 8; n++) cycle();
    endtask

    task automatic test_tag0();
        doReset();
        setRes(SRC_ADD, NULL_TAG, $urandom);
        vIn = 3'b001;
        cycle();
        vIn = '0;
        checks++;
        if (tag0Err !== 1'b1) begin errors++; $display("[TB] FAIL tag0_set: got %b expected 1", tag0Err); end
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks += 3;
            if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL tag0_nobus: got valid %b expected 0", cdbValid); end
            if (ready !== 3'b111) begin errors++; $display("[TB] FAIL tag0_ready: got %b expected 111", ready); end
            if (tag0Err !== 1'b1) begin errors++; $display("[TB] FAIL tag0_sticky: got %b expected 1", tag0Err); end
        end
        rst_n = 1'b0;
        #1;
        modelReset();
        checks++;
        if (tag0Err !== 1'b0) begin errors++; $display("[TB] FAIL tag0_clear: got %b expected 0", tag0Err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midstream();
        vIn = 3'b111;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < NSRC; i++) setRes(i, TAG_W'($urandom_range(1, 7)), $urandom);
            cycle();
        end
        checks++;
        if (cdbValid !== 1'b1 || cdb !== expCdb) begin
            errors++;
            $display("[TB] FAIL mid_busy: got %h/%b expected %h/1", cdb, cdbValid, expCdb);
        end
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checks += 3;
        if (cdb !== '0) begin errors++; $display("[TB] FAIL mid_cdb: got %h expected 0", cdb); end
        if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", cdbValid); end
        if (ready !== 3'b111) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 111", ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        setRes(SRC_ADD, A1, 32'h0A0A_0001);
        setRes(SRC_MULT, M1, 32'h0B0B_0002);
        setRes(SRC_LD, LD1, 32'h0C0C_0003);
        cycle();
        vIn = '0;
        cycle();
        checks += 2;
        if (cdb !== {A1, 32'h0A0A_0001}) begin errors++; $display("[TB] FAIL mid_first: got %h expected %h", cdb, {A1, 32'h0A0A_0001}); end
        if (cdb !== expCdb) begin errors++; $display("[TB] FAIL mid_model: got %h expected %h", cdb, expCdb); end
        for (int n = 0; n < 4; n++) cycle();
    endtask

    task automatic test_random();
        doReset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NSRC; i++) begin
                vIn[i] = ($urandom_range(0, 3) != 0);
                setRes(i, ($urandom_range(0, 15) == 0) ? NULL_TAG : TAG_W'($urandom_range(1, 7)), $urandom);
            end
            checks++;
            if (ready !== modelReady()) begin errors++; $display("[TB] FAIL rnd_ready: got %b expected %b", ready, modelReady()); end
            cycle();
            checks += 2;
            if (cdb !== expCdb || cdbValid !== expValid) begin
                errors++;
                $display("[TB] FAIL rnd_cdb: got %h/%b expected %h/%b", cdb, cdbValid, expCdb, expValid);
            end
            if (tag0Err !== expErr) begin errors++; $display("[TB] FAIL rnd_err: got %b expected %b", tag0Err, expErr); end
        end
        vIn = '0;
    endtask

    initial begin
        modelReset();
        test_reset();
        test_single_push();
        test_round_robin();
        test_back_pressure();
        test_tag0();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
